// File: rtl/serial_loader.sv
// serial_loader: receives framed bytes over an 8N1 UART and writes the
// payload into SDRAM through a single-request write interface.
//
// Frame: A5 | addr[7:0] | addr[15:8] | addr[22:16] | len[7:0] | len[15:8] | len data bytes
// Data bytes pass through a 4-entry FIFO so the UART never stalls on the
// SDRAM controller. When the FIFO is full, the byte is dropped and the sticky
// error flag is set.
module serial_loader #(
  parameter int CLK_PER_BIT = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [22:0] addr,
  output logic        rw,
  output logic [7:0]  data_in,
  output logic        in_valid,
  input  logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CNT_W = $clog2(CLK_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [2:0] {
    SYNC, ADR0, ADR1, ADR2, LEN0, LEN1, DATA
  } p_state_t;

  typedef enum logic [1:0] {
    W_IDLE, W_REQ, W_WAIT
  } w_state_t;

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t        rx_state_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_byte_q;
  logic             rx_valid_q;
  logic             rx_ferr_q;

  // Two-flop synchronizer on rx, plus a delayed copy to detect the falling edge.
  always_ff @(posedge clk) begin
    // NOTE: every sequential assignment is non-blocking. The three flops then
    // form a true shift chain, not one wire evaluated in program order.
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Bit-timing FSM: find the start edge, confirm it at mid-bit, then sample each bit at its centre.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q <= '0;
            if (!rx_sync_q) begin
              rx_bit_q   <= '0;
              rx_state_q <= RX_DATA;
            end else begin
              // Line went back high before mid-bit: a glitch, not a start bit.
              rx_state_q <= RX_IDLE;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q  <= '0;
            rx_byte_q <= {rx_sync_q, rx_byte_q[7:1]};
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q <= '0;
            if (rx_sync_q) begin
              rx_valid_q <= 1'b1;
              rx_state_q <= RX_IDLE;
            end else begin
              // Framing error. A low line here would look like a new start
              // bit, so wait for the line to return high first.
              rx_ferr_q  <= 1'b1;
              rx_state_q <= RX_WAIT_HIGH;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync_q) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage and control strobes
  // ---------------------------------------------------------------------------
  p_state_t    p_state_q;
  logic [22:0] waddr_q;
  logic [15:0] len_q;
  logic        err_q;

  logic [22:0] fifo_addr_q [4];
  logic [7:0]  fifo_data_q [4];
  logic        fifo_last_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  fifo_cnt_q;

  w_state_t    w_state_q;
  logic        w_first_q;

  logic        push_req, push, drop, pop, is_last;
  logic [1:0]  prev_ptr;

  // Decode this cycle's FIFO push, drop and pop.
  always_comb begin
    // NOTE: every output gets a default first. A path that leaves one
    // unassigned would infer a latch.
    push_req = 1'b0;
    push     = 1'b0;
    drop     = 1'b0;
    pop      = 1'b0;
    is_last  = 1'b0;
    prev_ptr = wr_ptr_q - 2'd1;
    pop      = (w_state_q == W_IDLE) && (fifo_cnt_q != 3'd0) && !busy;
    if (rx_valid_q && (p_state_q == DATA)) begin
      push_req = 1'b1;
      is_last  = (len_q == 16'd1);
      // A pop in the same cycle frees a slot, so a full FIFO can still accept the byte.
      if ((fifo_cnt_q != 3'd4) || pop) push = 1'b1;
      else                             drop = 1'b1;
    end
  end

  // Frame parser: one state step per received byte; a framing error forces resynchronisation.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_state_q <= SYNC;
      waddr_q   <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
    end else if (rx_ferr_q) begin
      p_state_q <= SYNC;
      err_q     <= 1'b1;
    end else if (rx_valid_q) begin
      case (p_state_q)
        SYNC: if (rx_byte_q == SYNC_BYTE) p_state_q <= ADR0;
        ADR0: begin
          waddr_q[7:0] <= rx_byte_q;
          p_state_q    <= ADR1;
        end
        ADR1: begin
          waddr_q[15:8] <= rx_byte_q;
          p_state_q     <= ADR2;
        end
        ADR2: begin
          waddr_q[22:16] <= rx_byte_q[6:0];
          p_state_q      <= LEN0;
        end
        LEN0: begin
          len_q[7:0] <= rx_byte_q;
          p_state_q  <= LEN1;
        end
        LEN1: begin
          len_q[15:8] <= rx_byte_q;
          p_state_q   <= ({rx_byte_q, len_q[7:0]} == 16'd0) ? SYNC : DATA;
        end
        DATA: begin
          // The address and count advance even when the byte is dropped,
          // so the following bytes still land at their own addresses.
          waddr_q <= waddr_q + 23'd1;
          len_q   <= len_q - 16'd1;
          if (drop) err_q <= 1'b1;
          if (is_last) p_state_q <= SYNC;
        end
        default: p_state_q <= SYNC;
      endcase
    end
  end

  // FIFO payload: address, data and end-of-frame marker for each queued byte.
  always_ff @(posedge clk) begin
    // NOTE: the payload array is not reset. Only slots between rd_ptr and
    // wr_ptr are ever read, and resetting the pointers makes them all invalid.
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= waddr_q;
      fifo_data_q[wr_ptr_q] <= rx_byte_q;
      fifo_last_q[wr_ptr_q] <= is_last;
    end else if (drop && is_last) begin
      // The frame's last byte did not fit. Move the end-of-frame marker to the
      // newest queued byte so done fires when the queue drains that far.
      fifo_last_q[prev_ptr] <= 1'b1;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 3'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 3'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // SDRAM write engine
  // ---------------------------------------------------------------------------
  logic [22:0] addr_q;
  logic [7:0]  data_q;
  logic        rw_q, in_valid_q, done_q;

  // Write engine: take the FIFO head, strobe one request, then wait for the controller to go idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      w_first_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rw_q       <= 1'b0;
      in_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      in_valid_q <= 1'b0;
      done_q     <= 1'b0;
      case (w_state_q)
        W_IDLE: begin
          if (pop) begin
            // Outputs are loaded here so they show the head in the W_REQ
            // cycle, and they hold until the next request.
            addr_q     <= fifo_addr_q[rd_ptr_q];
            data_q     <= fifo_data_q[rd_ptr_q];
            done_q     <= fifo_last_q[rd_ptr_q];
            rw_q       <= 1'b1;
            in_valid_q <= 1'b1;
            w_state_q  <= W_REQ;
          end
        end
        W_REQ: begin
          w_first_q <= 1'b1;
          w_state_q <= W_WAIT;
        end
        W_WAIT: begin
          // The controller may take a cycle to raise busy, so busy is not
          // checked in the first wait cycle.
          if (w_first_q)  w_first_q <= 1'b0;
          else if (!busy) w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign addr     = addr_q;
  assign data_in  = data_q;
  assign rw       = rw_q;
  assign in_valid = in_valid_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_serial_loader.sv
// Testbench for serial_loader. The stimulus side queues the writes each
// frame should produce. A separate monitor checks every in_valid strobe
// against the head of that queue.
module tb_serial_loader;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst, rx, busy;
  logic [22:0] addr;
  logic        rw, in_valid, done, err;
  logic [7:0]  data_in;

  typedef struct packed {
    logic [22:0] a;
    logic [7:0]  d;
    logic        dn;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] frm[$];
  int n_tests = 0, n_fail = 0, n_writes = 0, exp_writes = 0;

  serial_loader #(.CLK_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .addr(addr), .rw(rw), .data_in(data_in),
    .in_valid(in_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [22:0] a, input logic [7:0] d, input logic dn);
    exp_q.push_back({a, d, dn});
    exp_writes++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stop_bit) repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frm();
    foreach (frm[i]) send_byte(frm[i]);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: %0d writes still outstanding after timeout", name, exp_q.size());
      exp_q.delete();
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every write strobe must match the oldest expected write; done must never pulse on its own.
  always @(negedge clk) begin
    if (!rst && in_valid) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", addr, data_in);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(addr), 32'(mon_e.a));
        check("wr_data", 32'(data_in), 32'(mon_e.d));
        check("wr_done", 32'(done), 32'(mon_e.dn));
        check("wr_rw", 32'(rw), 32'd1);
      end
    end else if (!rst && done) begin
      n_tests++;
      n_fail++;
      $display("FAIL stray_done: done high without in_valid, got 1 expected 0");
    end
  end

  // Watchdog: stop the run if the stimulus never completes.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    rx   = 1'b1;
    busy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data", 32'(data_in), 32'd0);
    check("rst_rw", 32'(rw), 32'd0);
    check("rst_in_valid", 32'(in_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Basic three-byte frame
    frm = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
    expect_wr(23'h001000, 8'h11, 1'b0);
    expect_wr(23'h001001, 8'h22, 1'b0);
    expect_wr(23'h001002, 8'h33, 1'b1);
    send_frm();
    wait_drain("basic_drain");
    check("basic_err", 32'(err), 32'd0);

    // Address wrap at the top of the 23-bit space
    frm = '{8'hA5, 8'hFF, 8'hFF, 8'h7F, 8'h02, 8'h00, 8'hAA, 8'hBB};
    expect_wr(23'h7FFFFF, 8'hAA, 1'b0);
    expect_wr(23'h000000, 8'hBB, 1'b1);
    send_frm();
    wait_drain("wrap_drain");
    check("wrap_err", 32'(err), 32'd0);

    // Zero-length frame produces nothing
    frm = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frm();
    repeat (200) @(negedge clk);
    check("zero_len_writes", 32'(n_writes), 32'(exp_writes));

    // Short low glitch inside a frame must not become a data byte
    frm = '{8'hA5, 8'h00, 8'h50, 8'h00, 8'h01, 8'h00};
    send_frm();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    expect_wr(23'h005000, 8'h5C, 1'b1);
    send_byte(8'h5C);
    wait_drain("glitch_drain");
    check("glitch_err", 32'(err), 32'd0);

    // FIFO overflow with busy held high: 4 queued, 2 dropped
    busy = 1'b1;
    frm = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h06, 8'h00,
            8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
    send_frm();
    repeat (20) @(negedge clk);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_no_write_while_busy", 32'(n_writes), 32'(exp_writes));
    expect_wr(23'h002000, 8'hD0, 1'b0);
    expect_wr(23'h002001, 8'hD1, 1'b0);
    expect_wr(23'h002002, 8'hD2, 1'b0);
    expect_wr(23'h002003, 8'hD3, 1'b1);
    busy = 1'b0;
    wait_drain("ovf_drain");

    // Framing error in ADR1, then a good frame (ADR2 bit 7 ignored)
    do_reset();
    check("ferr_pre_err", 32'(err), 32'd0);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h10, 1'b0);
    repeat (5) @(negedge clk);
    check("ferr_err", 32'(err), 32'd1);
    frm = '{8'hA5, 8'h34, 8'h12, 8'h85, 8'h01, 8'h00, 8'h77};
    expect_wr(23'h051234, 8'h77, 1'b1);
    send_frm();
    wait_drain("ferr_drain");
    check("ferr_err_sticky", 32'(err), 32'd1);

    // Reset mid-frame with 3 of 5 bytes queued
    busy = 1'b1;
    frm = '{8'hA5, 8'h00, 8'h30, 8'h00, 8'h05, 8'h00, 8'hE0, 8'hE1, 8'hE2};
    send_frm();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_addr", 32'(addr), 32'd0);
    check("midrst_data", 32'(data_in), 32'd0);
    check("midrst_rw", 32'(rw), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_in_valid", 32'(in_valid), 32'd0);
    busy = 1'b0;
    repeat (100) @(negedge clk);
    check("midrst_no_writes", 32'(n_writes), 32'(exp_writes));
    frm = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h01, 8'h00, 8'h99};
    expect_wr(23'h004000, 8'h99, 1'b1);
    send_frm();
    wait_drain("midrst_drain");

    check("total_writes", 32'(n_writes), 32'(exp_writes));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
